// File: rtl/numarator_ture_pkg.sv
// rtl/numarator_ture_pkg.sv - shared FSM states, circuit mode codes and timing defaults for the lap counter
package numarator_ture_pkg;

    typedef enum logic [1:0] {
        ASTEPT   = 2'd0,
        CONFIRM  = 2'd1,
        PE_LINIE = 2'd2,
        BLOCARE  = 2'd3
    } stare_t;

    typedef enum logic [1:0] {
        CIRC_ANDURANTA = 2'b00,
        CIRC_TURA      = 2'b01,
        CIRC_CURBE     = 2'b10
    } circuit_t;

    localparam int unsigned DEBOUNCE_CYC_DEF = 50000;
    localparam int unsigned LOCKOUT_CYC_DEF  = 25000000;
    localparam logic [3:0]  TURE_MAX         = 4'd15;

endpackage

// File: rtl/numarator_ture_sincronizator.sv
// rtl/numarator_ture_sincronizator.sv - two-flop synchronizer for the asynchronous finish-line detect
module sincronizator (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/numarator_ture.sv
// rtl/numarator_ture.sv - debounced finish-line lap counter with post-line lockout and mode-change clear
module numarator_ture
    import numarator_ture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned LOCKOUT_CYC  = LOCKOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tact_count,
    input  logic [1:0] circuit,
    output logic [3:0] count_ture,
    output logic       puls_tura,
    output logic       saturat
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned LCK_W = $clog2(LOCKOUT_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCKOUT_CYC - 1);

    logic             ts;
    stare_t           stare_q, stare_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [LCK_W-1:0] lck_q, lck_d;
    logic [3:0]       count_q, count_d;
    logic             puls_q, puls_d;
    logic             sat_q, sat_d;
    logic [1:0]       circ_q;

    sincronizator u_sinc (
        .clk (clk),
        .rst (rst),
        .d_i (tact_count),
        .q_o (ts)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stare_q <= ASTEPT;
            deb_q   <= '0;
            lck_q   <= '0;
            count_q <= '0;
            puls_q  <= 1'b0;
            sat_q   <= 1'b0;
            circ_q  <= CIRC_ANDURANTA;
        end else begin
            stare_q <= stare_d;
            deb_q   <= deb_d;
            lck_q   <= lck_d;
            count_q <= count_d;
            puls_q  <= puls_d;
            sat_q   <= sat_d;
            circ_q  <= circuit;
        end
    end

    always_comb begin
        stare_d = stare_q;
        deb_d   = deb_q;
        lck_d   = lck_q;
        count_d = count_q;
        puls_d  = 1'b0;

        // Timers stop at their last value, so they can never wrap.
        unique case (stare_q)
            ASTEPT: begin
                if (ts) begin
                    stare_d = CONFIRM;
                    deb_d   = '0;
                end
            end
            CONFIRM: begin
                if (!ts) begin
                    stare_d = ASTEPT;
                end else if (deb_q == DEB_LAST) begin
                    stare_d = PE_LINIE;
                    if (count_q != TURE_MAX) begin
                        count_d = count_q + 4'd1;
                        puls_d  = 1'b1;
                    end
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            PE_LINIE: begin
                if (!ts) begin
                    stare_d = BLOCARE;
                    lck_d   = '0;
                end
            end
            BLOCARE: begin
                if (lck_q == LCK_LAST) begin
                    stare_d = ASTEPT;
                end else begin
                    lck_d = lck_q + 1'b1;
                end
            end
            default: stare_d = ASTEPT;
        endcase

        // A mode switch restarts the count and wins over a coinciding lap.
        if (circuit != circ_q) begin
            stare_d = ASTEPT;
            deb_d   = '0;
            lck_d   = '0;
            count_d = '0;
            puls_d  = 1'b0;
        end

        sat_d = (count_d == TURE_MAX);
    end

    assign count_ture = count_q;
    assign puls_tura  = puls_q;
    assign saturat    = sat_q;

endmodule

// File: tb/tb_numarator_ture.sv
// tb/tb_numarator_ture.sv - self-checking bench for the lap counter
module tb_numarator_ture;

    localparam int DEB = 4;
    localparam int LCK = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tact_count = 1'b0;
    logic [1:0] circuit = 2'b00;
    logic [3:0] count_ture;
    logic       puls_tura;
    logic       saturat;

    always #5 clk = ~clk;

    numarator_ture #(
        .DEBOUNCE_CYC (DEB),
        .LOCKOUT_CYC  (LCK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tact_count (tact_count),
        .circuit    (circuit),
        .count_ture (count_ture),
        .puls_tura  (puls_tura),
        .saturat    (saturat)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_seen = 0;

    int m_cyc, m_s1, m_s2, m_circ, m_count, m_pulse, m_sat;
    int m_online, m_conf_from, m_lock_until;

    typedef struct {
        logic       tact;
        logic [1:0] circ;
        int         len;
        int         exp_count;
        int         exp_pulses;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_s1 = 0; m_s2 = 0; m_circ = 0;
        m_count = 0; m_pulse = 0; m_sat = 0;
        m_online = 0; m_conf_from = -1; m_lock_until = -1000;
    endtask

    // Timestamp model: a lap is seen when the synchronized line has been high
    // DEB cycles after arming, and arming is blocked LCK cycles after leaving the line.
    task automatic model_edge();
        int ts;
        int n;
        m_cyc++;
        n = m_cyc;
        ts = m_s2;
        m_pulse = 0;
        if (int'(circuit) != m_circ) begin
            m_count = 0; m_online = 0; m_conf_from = -1; m_lock_until = -1000;
        end else if (m_online != 0) begin
            if (ts == 0) begin
                m_online = 0;
                m_lock_until = n + LCK;
            end
        end else if (n <= m_lock_until) begin
            m_online = 0;
        end else if (m_conf_from >= 0) begin
            if (ts == 0) begin
                m_conf_from = -1;
            end else if (n - m_conf_from == DEB) begin
                m_online = 1;
                m_conf_from = -1;
                if (m_count < 15) begin
                    m_count++;
                    m_pulse = 1;
                end
            end
        end else if (ts != 0) begin
            m_conf_from = n;
        end
        m_sat = (m_count == 15) ? 1 : 0;
        m_s2 = m_s1;
        m_s1 = int'(tact_count);
        m_circ = int'(circuit);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        pulse_seen += int'(puls_tura);
        check("model_count", int'(count_ture), m_count);
        check("model_pulse", int'(puls_tura), m_pulse);
        check("model_saturat", int'(saturat), m_sat);
    endtask

    task automatic do_reset();
        tact_count = 1'b0;
        circuit = 2'b00;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_count", int'(count_ture), 0);
        check("reset_pulse", int'(puls_tura), 0);
        check("reset_saturat", int'(saturat), 0);
    endtask

    task automatic lap();
        tact_count = 1'b1;
        repeat (8) step();
        tact_count = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        tbl.push_back('{1'b0, 2'b00,  4, 0, 0});
        tbl.push_back('{1'b1, 2'b00,  3, 0, 0});
        tbl.push_back('{1'b0, 2'b00,  6, 0, 0});
        tbl.push_back('{1'b1, 2'b00,  4, 0, 0});
        tbl.push_back('{1'b0, 2'b00,  6, 0, 0});
        tbl.push_back('{1'b1, 2'b00, 20, 1, 1});
        tbl.push_back('{1'b0, 2'b00,  2, 1, 0});
        tbl.push_back('{1'b1, 2'b00,  5, 1, 0});
        tbl.push_back('{1'b0, 2'b00, 10, 1, 0});
        tbl.push_back('{1'b1, 2'b00,  5, 1, 0});
        tbl.push_back('{1'b0, 2'b00, 12, 2, 1});
        tbl.push_back('{1'b0, 2'b10,  3, 0, 0});

        do_reset();
        foreach (tbl[i]) begin
            tact_count = tbl[i].tact;
            circuit = tbl[i].circ;
            pulse_seen = 0;
            repeat (tbl[i].len) step();
            check($sformatf("tbl%0d_count", i), int'(count_ture), tbl[i].exp_count);
            check($sformatf("tbl%0d_pulses", i), pulse_seen, tbl[i].exp_pulses);
        end

        do_reset();
        pulse_seen = 0;
        repeat (17) lap();
        check("sat_count", int'(count_ture), 15);
        check("sat_flag", int'(saturat), 1);
        check("sat_pulses", pulse_seen, 15);

        do_reset();
        repeat (3) lap();
        check("mode_pre_count", int'(count_ture), 3);
        tact_count = 1'b1;
        repeat (6) step();
        circuit = 2'b10;
        step();
        check("mode_clear_count", int'(count_ture), 0);
        check("mode_no_pulse", int'(puls_tura), 0);
        repeat (4) step();
        check("mode_redebounce_wait", int'(count_ture), 0);
        step();
        check("mode_redebounce_count", int'(count_ture), 1);
        tact_count = 1'b0;
        repeat (12) step();
        repeat (4) lap();
        check("arst_pre_count", int'(count_ture), 5);

        tact_count = 1'b1;
        repeat (4) step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_count", int'(count_ture), 0);
        check("arst_pulse", int'(puls_tura), 0);
        check("arst_saturat", int'(saturat), 0);
        #1;
        rst = 1'b0;
        repeat (6) step();
        check("arst_hold_wait", int'(count_ture), 0);
        step();
        check("arst_hold_count", int'(count_ture), 1);

        do_reset();
        for (int r = 0; r < 150; r++) begin
            tact_count = ~tact_count;
            if ($urandom_range(0, 24) == 0) circuit = 2'($urandom_range(0, 2));
            repeat ($urandom_range(1, 14)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/numarator_ture.md
NUMARATOR_TURE -- requirements
Module: numarator_ture

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 50000; cycles the finish-line pattern must hold before it is accepted (1 ms at 50 MHz).
REQ-002 Parameter LOCKOUT_CYC, default 25000000; cycles after line release during which new line detections are ignored (0.5 s at 50 MHz).
REQ-003 Port clk, input, 1; single system clock, all state on rising edge.
REQ-004 Port rst, input, 1; asynchronous, active-high reset.
REQ-005 Port tact_count, input, 1; raw combinational finish-line detect (all four outer sensors on black), asynchronous to clk, glitchy.
REQ-006 Port circuit, input, 2; selected circuit mode (00 endurance/run, 01 single lap, 10 ten-lap curve test).
REQ-007 Port count_ture, output, 4; registered number of completed laps, fed back to the motion-logic block.
REQ-008 Port puls_tura, output, 1; one-cycle pulse in the cycle count_ture increments.
REQ-009 Port saturat, output, 1; high while count_ture equals 15.

Function
REQ-010 tact_count SHALL pass through a 2-flop synchronizer; only the second flop output (ts) is used internally.
REQ-011 FSM states: ASTEPT (waiting for line), CONFIRM (debouncing), PE_LINIE (on line, lap counted), BLOCARE (lockout).
REQ-012 ASTEPT: ts=1 -> CONFIRM with debounce counter cleared; ts=0 -> stay.
REQ-013 CONFIRM: ts=0 -> ASTEPT (glitch rejected, no count); ts=1 for DEBOUNCE_CYC consecutive cycles in CONFIRM -> PE_LINIE.
REQ-014 On the CONFIRM->PE_LINIE transition, count_ture SHALL increment by 1 and puls_tura SHALL be 1 in the next cycle only, so count_ture and puls_tura update together, 1 cycle after the qualifying sample.
REQ-015 PE_LINIE: ts=1 -> stay (no further counting however long the car sits on the line); ts=0 -> BLOCARE with lockout counter cleared.
REQ-016 BLOCARE: ignore ts; after LOCKOUT_CYC cycles -> ASTEPT; a ts=1 during BLOCARE is never counted.
REQ-017 count_ture SHALL saturate at 15: at 15 a qualifying detection still walks the FSM but neither increments nor pulses; saturat=1 from that point.
REQ-018 A registered copy of circuit SHALL be kept; any change of circuit versus the copy SHALL, in that cycle, clear count_ture to 0, force FSM to ASTEPT, clear both timers and suppress puls_tura; the increment is dropped if it coincides.
REQ-019 Timer widths SHALL be ceil(log2(param+1)); counters SHALL NOT wrap; a parameter of 1 means a single cycle of hold or lockout.
REQ-020 All outputs SHALL be registered; no combinational path from tact_count or circuit to any output.

Reset
REQ-021 rst=1 SHALL asynchronously set: count_ture=0, puls_tura=0, saturat=0, FSM=ASTEPT, both timers=0, synchronizer flops=0, circuit copy=00.
REQ-022 Reset asserted mid-debounce or mid-lockout SHALL abandon the event with no count; release is synchronous to clk in the implementation's reset-release path.

Structure
REQ-023 A shared package SHALL hold the FSM state enumeration, the circuit mode codes (00, 01, 10) and the default timing constants, for reuse by the motion-logic and display blocks.
REQ-024 One sub-module, sincronizator (2-flop synchronizer, asynchronously reset to 0), SHALL be instantiated for tact_count; everything else stays flat.

Verification (DEBOUNCE_CYC=4, LOCKOUT_CYC=8 for simulation)
REQ-025 Glitch: tact_count high for 3 synchronized cycles, then low -> count_ture stays 0, no puls_tura.
REQ-026 Clean lap: tact_count high 20 cycles -> exactly one puls_tura, count_ture 0->1, one cycle after the 4th high sample.
REQ-027 Bounce after line: high 10 cycles, low 2, high 5 (inside lockout) -> count_ture=1 only; after 8 low cycles plus a fresh 4-cycle hold -> count_ture=2.
REQ-028 Saturation: 17 clean laps -> count_ture=15, saturat=1, 15 puls_tura pulses total.
REQ-029 Mode change: count_ture=3, circuit 00->10 -> count_ture=0 the next cycle, FSM in ASTEPT; a simultaneous qualifying detection produces no pulse.
REQ-030 Async reset: rst pulsed mid-CONFIRM with count_ture=5 and no clk edge -> all outputs 0 immediately; after release, the held line needs a full 4-cycle debounce to count.
